mc_ctrl: RTL and testbench



---
 rtl/mc_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mc_ctrl
//  Purpose  : Main control FSM of the multicycle MIPS datapath (mccomp).
//  Revision : 1.0  initial release
// ============================================================================
module mc_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] wd_sel,
    output logic       alu_srca,
    output logic [1:0] alu_srcb,
    output logic [3:0] alu_op,
    output logic       ext_op,
    output logic [1:0] pc_src,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXE    = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IEXE   = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [3:0] c_ALU_ADD = 4'd0;
    localparam logic [3:0] c_ALU_SUB = 4'd1;
    localparam logic [3:0] c_ALU_AND = 4'd2;
    localparam logic [3:0] c_ALU_OR  = 4'd3;
    localparam logic [3:0] c_ALU_SLT = 4'd4;

    state_t r_state;
    state_t w_next;

    logic       w_rtype, w_r_alu, w_jr;
    logic       w_lw, w_sw, w_beq, w_bne, w_addi, w_ori, w_j, w_jal;
    logic [3:0] w_funct_alu;

    logic       w_pc_en, w_iord, w_mem_write, w_ir_write, w_reg_write;
    logic [1:0] w_reg_dst, w_wd_sel, w_alu_srcb, w_pc_src;
    logic       w_alu_srca, w_ext_op, w_illegal;
    logic [3:0] w_alu_op;

    assign w_rtype = (op == 6'h00);
    assign w_jr    = w_rtype && (funct == 6'h08);
    assign w_lw    = (op == 6'h23);
    assign w_sw    = (op == 6'h2B);
    assign w_beq   = (op == 6'h04);
    assign w_bne   = (op == 6'h05);
    assign w_addi  = (op == 6'h08);
    assign w_ori   = (op == 6'h0D);
    assign w_j     = (op == 6'h02);
    assign w_jal   = (op == 6'h03);

    always_comb begin
        w_r_alu     = w_rtype;
        w_funct_alu = c_ALU_ADD;
        case (funct)
            6'h20:   w_funct_alu = c_ALU_ADD;
            6'h22:   w_funct_alu = c_ALU_SUB;
            6'h24:   w_funct_alu = c_ALU_AND;
            6'h25:   w_funct_alu = c_ALU_OR;
            6'h2A:   w_funct_alu = c_ALU_SLT;
            default: w_r_alu     = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = S_FETCH;
        w_pc_en     = 1'b0;
        w_iord      = 1'b0;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_reg_dst   = 2'd0;
        w_wd_sel    = 2'd0;
        w_alu_srca  = 1'b0;
        w_alu_srcb  = 2'd0;
        w_alu_op    = c_ALU_ADD;
        w_ext_op    = 1'b1;
        w_pc_src    = 2'd0;
        w_illegal   = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_ir_write = 1'b1;
                w_alu_srcb = 2'd1;
                w_pc_en    = 1'b1;
                w_next     = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is computed speculatively into ALUOut.
                w_alu_srcb = 2'd3;
                if (w_lw || w_sw)                  w_next = S_MEMADR;
                else if (w_r_alu)                  w_next = S_EXE;
                else if (w_jr || w_j || w_jal)     w_next = S_JUMP;
                else if (w_beq || w_bne)           w_next = S_BRANCH;
                else if (w_addi || w_ori)          w_next = S_IEXE;
                else begin
                    w_illegal = 1'b1;
                    w_next    = S_FETCH;
                end
            end
            S_MEMADR: begin
                w_alu_srca = 1'b1;
                w_alu_srcb = 2'd2;
                w_next     = w_sw ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                w_iord = 1'b1;
                w_next = S_MEMWB;
            end
            S_MEMWB: begin
                // Address kept on ALUOut so the memory port stays quiet on PC.
                w_iord      = 1'b1;
                w_reg_write = 1'b1;
                w_wd_sel    = 2'd1;
            end
            S_MEMWR: begin
                w_iord      = 1'b1;
                w_mem_write = 1'b1;
            end
            S_EXE: begin
                w_alu_srca = 1'b1;
                w_alu_op   = w_funct_alu;
                w_next     = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_reg_dst   = 2'd1;
            end
            S_BRANCH: begin
                w_alu_srca = 1'b1;
                w_alu_op   = c_ALU_SUB;
                w_pc_src   = 2'd1;
                w_pc_en    = w_bne ? ~zero : zero;
            end
            S_IEXE: begin
                w_alu_srca = 1'b1;
                w_alu_srcb = 2'd2;
                w_alu_op   = w_ori ? c_ALU_OR : c_ALU_ADD;
                w_ext_op   = ~w_ori;
                w_next     = S_IWB;
            end
            S_IWB: begin
                w_reg_write = 1'b1;
                w_ext_op    = ~w_ori;
            end
            S_JUMP: begin
                w_pc_en  = 1'b1;
                w_pc_src = w_jr ? 2'd3 : 2'd2;
                if (w_jal) begin
                    w_reg_write = 1'b1;
                    w_reg_dst   = 2'd2;
                    w_wd_sel    = 2'd2;
                end
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Reset masks every side-effecting output, whatever the current state.
    assign pc_en     = w_pc_en     & ~rst;
    assign mem_write = w_mem_write & ~rst;
    assign ir_write  = w_ir_write  & ~rst;
    assign reg_write = w_reg_write & ~rst;
    assign illegal   = w_illegal   & ~rst;

    assign iord     = w_iord;
    assign reg_dst  = w_reg_dst;
    assign wd_sel   = w_wd_sel;
    assign alu_srca = w_alu_srca;
    assign alu_srcb = w_alu_srcb;
    assign alu_op   = w_alu_op;
    assign ext_op   = w_ext_op;
    assign pc_src   = w_pc_src;
    assign state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mc_ctrl
//  Purpose  : Directed scoreboard bench for the multicycle MIPS control FSM.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mc_ctrl;

    logic       clk;
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pc_en, iord, mem_write, ir_write, reg_write;
    logic [1:0] reg_dst, wd_sel, alu_srcb, pc_src;
    logic       alu_srca, ext_op, illegal;
    logic [3:0] alu_op, state;

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] wd_sel;
        logic       alu_srca;
        logic [1:0] alu_srcb;
        logic [3:0] alu_op;
        logic       ext_op;
        logic [1:0] pc_src;
        logic       illegal;
        logic [3:0] state;
    } out_t;

    typedef struct {
        out_t  v;
        string tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    mc_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .op       (op),
        .funct    (funct),
        .zero     (zero),
        .pc_en    (pc_en),
        .iord     (iord),
        .mem_write(mem_write),
        .ir_write (ir_write),
        .reg_write(reg_write),
        .reg_dst  (reg_dst),
        .wd_sel   (wd_sel),
        .alu_srca (alu_srca),
        .alu_srcb (alu_srcb),
        .alu_op   (alu_op),
        .ext_op   (ext_op),
        .pc_src   (pc_src),
        .illegal  (illegal),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are compared mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            out_t obs;
            e = q.pop_front();
            obs.pc_en     = pc_en;
            obs.iord      = iord;
            obs.mem_write = mem_write;
            obs.ir_write  = ir_write;
            obs.reg_write = reg_write;
            obs.reg_dst   = reg_dst;
            obs.wd_sel    = wd_sel;
            obs.alu_srca  = alu_srca;
            obs.alu_srcb  = alu_srcb;
            obs.alu_op    = alu_op;
            obs.ext_op    = ext_op;
            obs.pc_src    = pc_src;
            obs.illegal   = illegal;
            obs.state     = state;
            checks++;
            assert (obs === e.v) else begin
                errors++;
                $error("FAIL %s observed=%06h expected=%06h", e.tag, obs, e.v);
            end
        end
    end

    function automatic out_t mk(input logic [3:0] st);
        out_t o;
        o        = '0;
        o.ext_op = 1'b1;
        o.state  = st;
        return o;
    endfunction

    task automatic step(input out_t v, input string tag);
        exp_t e;
        e.v   = v;
        e.tag = tag;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic fd(input logic [5:0] i_op, input logic [5:0] i_fn,
                      input logic i_ill, input string tag);
        out_t e;
        op    = i_op;
        funct = i_fn;
        e = mk(4'd0); e.ir_write = 1'b1; e.alu_srcb = 2'd1; e.pc_en = 1'b1;
        step(e, {tag, "_fetch"});
        e = mk(4'd1); e.alu_srcb = 2'd3; e.illegal = i_ill;
        step(e, {tag, "_decode"});
    endtask

    task automatic memadr(input string tag);
        out_t e;
        e = mk(4'd2); e.alu_srca = 1'b1; e.alu_srcb = 2'd2;
        step(e, {tag, "_memadr"});
    endtask

    task automatic run_lw();
        out_t e;
        fd(6'h23, 6'h00, 1'b0, "lw");
        memadr("lw");
        e = mk(4'd3); e.iord = 1'b1;
        step(e, "lw_memrd");
        e = mk(4'd4); e.iord = 1'b1; e.reg_write = 1'b1; e.wd_sel = 2'd1;
        step(e, "lw_memwb");
    endtask

    task automatic run_sw();
        out_t e;
        fd(6'h2B, 6'h00, 1'b0, "sw");
        memadr("sw");
        e = mk(4'd5); e.iord = 1'b1; e.mem_write = 1'b1;
        step(e, "sw_memwr");
    endtask

    task automatic run_r(input logic [5:0] i_fn, input logic [3:0] i_aop, input string tag);
        out_t e;
        fd(6'h00, i_fn, 1'b0, tag);
        e = mk(4'd6); e.alu_srca = 1'b1; e.alu_op = i_aop;
        step(e, {tag, "_exe"});
        e = mk(4'd7); e.reg_write = 1'b1; e.reg_dst = 2'd1;
        step(e, {tag, "_aluwb"});
    endtask

    task automatic run_br(input logic [5:0] i_op, input logic i_z, input logic i_take,
                          input string tag);
        out_t e;
        fd(i_op, 6'h00, 1'b0, tag);
        zero = i_z;
        e = mk(4'd8); e.alu_srca = 1'b1; e.alu_op = 4'd1; e.pc_src = 2'd1; e.pc_en = i_take;
        step(e, {tag, "_branch"});
        zero = 1'b0;
    endtask

    task automatic run_imm(input logic [5:0] i_op, input logic [3:0] i_aop, input logic i_ext,
                           input string tag);
        out_t e;
        fd(i_op, 6'h00, 1'b0, tag);
        e = mk(4'd9); e.alu_srca = 1'b1; e.alu_srcb = 2'd2; e.alu_op = i_aop; e.ext_op = i_ext;
        step(e, {tag, "_iexe"});
        e = mk(4'd10); e.reg_write = 1'b1; e.ext_op = i_ext;
        step(e, {tag, "_iwb"});
    endtask

    task automatic run_jmp(input logic [5:0] i_op, input logic [5:0] i_fn, input logic [1:0] i_src,
                           input logic i_link, input string tag);
        out_t e;
        fd(i_op, i_fn, 1'b0, tag);
        e = mk(4'd11); e.pc_en = 1'b1; e.pc_src = i_src;
        if (i_link) begin
            e.reg_write = 1'b1; e.reg_dst = 2'd2; e.wd_sel = 2'd2;
        end
        step(e, {tag, "_jump"});
    endtask

    initial begin
        out_t e;
        rst   = 1'b1;
        op    = 6'h00;
        funct = 6'h00;
        zero  = 1'b0;
        @(posedge clk);
        #1;
        // In reset: FETCH selects visible, every enable masked.
        e = mk(4'd0); e.alu_srcb = 2'd1;
        step(e, "rst_hold");
        rst = 1'b0;

        run_lw();
        run_sw();
        run_r(6'h20, 4'd0, "add");
        run_r(6'h22, 4'd1, "sub");
        run_r(6'h24, 4'd2, "and");
        run_r(6'h25, 4'd3, "or");
        run_r(6'h2A, 4'd4, "slt");
        run_br(6'h04, 1'b1, 1'b1, "beq_z1");
        run_br(6'h04, 1'b0, 1'b0, "beq_z0");
        run_br(6'h05, 1'b1, 1'b0, "bne_z1");
        run_br(6'h05, 1'b0, 1'b1, "bne_z0");
        run_imm(6'h08, 4'd0, 1'b1, "addi");
        run_imm(6'h0D, 4'd3, 1'b0, "ori");
        run_jmp(6'h02, 6'h00, 2'd2, 1'b0, "j");
        run_jmp(6'h03, 6'h00, 2'd2, 1'b1, "jal");
        run_jmp(6'h00, 6'h08, 2'd3, 1'b0, "jr");
        fd(6'h3F, 6'h00, 1'b1, "ill_op");
        fd(6'h00, 6'h00, 1'b1, "ill_funct");

        // Reset lands while sw sits in MEMWR: the write must be suppressed.
        fd(6'h2B, 6'h00, 1'b0, "swrst");
        memadr("swrst");
        rst = 1'b1;
        e = mk(4'd5); e.iord = 1'b1;
        step(e, "swrst_memwr");
        rst = 1'b0;
        run_r(6'h20, 4'd0, "add_after_rst");

        @(negedge clk);
        #1;
        checks++;
        assert (q.size() == 0) else begin
            errors++;
            $error("FAIL queue_drain observed=%0d expected=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
